// File: rtl/outport_uart_tx_pkg.sv
// ============================================================================
// Module      : outport_uart_tx_pkg
// Description : Shared encodings and sizes for the OUTPORT serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package outport_uart_tx_pkg;

    // Transmit FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int BITS_PER_BYTE  = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = BITS_PER_BYTE * BYTES_PER_WORD;

endpackage

`default_nettype wire

// File: rtl/outport_uart_tx_word_fifo.sv
// ============================================================================
// Module      : word_fifo
// Description : Synchronous first-word-fall-through FIFO with registered flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int               c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [c_PTR_W:0] c_CNT_ONE   = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [c_PTR_W:0] c_CNT_FULL  = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_full;
    logic               r_empty;

    logic               w_do_push;
    logic               w_do_pop;
    logic [c_PTR_W:0]   w_count_next;

    // Flags come from registers, so a same-cycle pop never rescues a push into a full FIFO
    assign w_do_push = push & ~r_full;
    assign w_do_pop  = pop  & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_CNT_FULL);
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;

endmodule

`default_nettype wire

// File: rtl/outport_uart_tx.sv
// ============================================================================
// Module      : outport_uart_tx
// Description : Buffers OUTPORT words and sends each as four 8N1 frames, LSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module outport_uart_tx
    import outport_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_LAST_BIT  = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0]  c_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]            r_state;
    logic [15:0]           r_baud_cnt;
    logic [2:0]            r_bit_idx;
    logic [1:0]            r_byte_idx;
    logic [WORD_WIDTH-1:0] r_shift_word;
    logic                  r_tx;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_baud_done;
    logic [2:0]            w_next_bit;
    logic [WORD_WIDTH-1:0] w_head_word;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_head_word),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_baud_done = (r_baud_cnt == c_BAUD_LAST);
    assign w_next_bit  = r_bit_idx + 3'd1;

    // Pop from IDLE, or at the end of a word's last stop bit so queued words run seamlessly
    assign w_pop = ~w_empty & ((r_state == IDLE) |
                   ((r_state == STOP) & w_baud_done & (r_byte_idx == c_LAST_BYTE)));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_shift_word <= '0;
            r_tx         <= 1'b1;
            r_overflow   <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift_word <= w_head_word;
                        r_byte_idx   <= '0;
                        r_tx         <= 1'b0;
                        r_state      <= START;
                    end
                end

                START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift_word[{r_byte_idx, 3'd0}];
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= w_next_bit;
                            r_tx      <= r_shift_word[{r_byte_idx, w_next_bit}];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_byte_idx != c_LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else if (w_pop) begin
                            r_shift_word <= w_head_word;
                            r_byte_idx   <= '0;
                            r_tx         <= 1'b0;
                            r_state      <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != IDLE) | ~w_empty;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
